// File: rtl/capture_arb_pkg.sv
// Shared types and constants for the capture arbiter: FSM state encoding,
// statistics counter width and requester index width helper.
package capture_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  localparam int unsigned CAP_COUNT_W  = 16;
  localparam int unsigned SETTLE_CNT_W = 8;

  // Index width for n requesters, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping at NREQ, reported as index and one-hot.
module rr_pick
  import capture_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   winner,
  output logic [NREQ-1:0] onehot
);

  logic [IW-1:0] idx_w;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    onehot = '0;
    idx_w  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx_w = IW'((32'(ptr) + i) % NREQ);
      if (!valid && req[idx_w]) begin
        valid         = 1'b1;
        winner        = idx_w;
        onehot[idx_w] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/capture_arbiter.sv
// Round-robin arbiter granting one requester a settle window, then capturing
// its data into a shared register. Define CAPTURE_ARB_STATS_EN to add cap_count.
module capture_arbiter
  import capture_arb_pkg::*;
#(
  parameter  int unsigned NREQ       = 4,
  parameter  int unsigned DW         = 8,
  parameter  int unsigned SETTLE_CYC = 3,
  localparam int unsigned IW         = idx_width(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] din,
  output logic [NREQ-1:0]    grant,
  output logic               cap_en,
  output logic [DW-1:0]      q,
  output logic               done,
  output logic [IW-1:0]      done_id,
  output logic               busy
`ifdef CAPTURE_ARB_STATS_EN
  ,
  output logic [CAP_COUNT_W-1:0] cap_count
`endif
);

  state_e                  state_q, state_d;
  logic [NREQ-1:0]         grant_q, grant_d;
  logic                    cap_en_q, cap_en_d;
  logic                    done_q, done_d;
  logic [IW-1:0]           done_id_q, done_id_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [IW-1:0]           winner_q, winner_d;
  logic [DW-1:0]           q_q, q_d;
  logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;

  logic                    pick_valid;
  logic [IW-1:0]           pick_idx;
  logic [NREQ-1:0]         pick_onehot;
  logic [DW-1:0]           win_data;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .winner (pick_idx),
    .onehot (pick_onehot)
  );

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (winner_q == IW'(i)) win_data = din[i*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      cap_en_q  <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      ptr_q     <= '0;
      winner_q  <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      cap_en_q  <= cap_en_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      ptr_q     <= ptr_d;
      winner_q  <= winner_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cap_en_d  = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    ptr_d     = ptr_q;
    winner_d  = winner_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick_valid) begin
          state_d  = SETTLE;
          grant_d  = pick_onehot;
          winner_d = pick_idx;
          cnt_d    = SETTLE_CNT_W'(SETTLE_CYC - 1);
        end
      end
      SETTLE: begin
        // Abort has priority over the counter reaching zero.
        if (!(|(req & grant_q))) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d  = CAPTURE;
          cap_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q - SETTLE_CNT_W'(1);
        end
      end
      CAPTURE: begin
        state_d   = IDLE;
        grant_d   = '0;
        done_d    = 1'b1;
        done_id_d = winner_q;
        q_d       = win_data;
        ptr_d     = (winner_q == IW'(NREQ - 1)) ? '0 : winner_q + IW'(1);
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign grant   = grant_q;
  assign cap_en  = cap_en_q;
  assign q       = q_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign busy    = (state_q != IDLE);

`ifdef CAPTURE_ARB_STATS_EN
  logic [CAP_COUNT_W-1:0] cap_count_q;

  always_ff @(posedge clk) begin
    if (reset) cap_count_q <= '0;
    else if (cap_en_q) cap_count_q <= cap_count_q + CAP_COUNT_W'(1);
  end

  assign cap_count = cap_count_q;
`endif

endmodule

// File: tb/tb_capture_arbiter.sv
// Directed self-checking bench for capture_arbiter (NREQ=4, DW=8, SETTLE_CYC=3).
module tb_capture_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  grant;
  logic        cap_en;
  logic [7:0]  q;
  logic        done;
  logic [1:0]  done_id;
  logic        busy;
`ifdef CAPTURE_ARB_STATS_EN
  logic [15:0] cap_count;
`endif

  int checks   = 0;
  int failures = 0;

  capture_arbiter #(
    .NREQ       (4),
    .DW         (8),
    .SETTLE_CYC (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .din     (din),
    .grant   (grant),
    .cap_en  (cap_en),
    .q       (q),
    .done    (done),
    .done_id (done_id),
    .busy    (busy)
`ifdef CAPTURE_ARB_STATS_EN
    ,
    .cap_count (cap_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with all requests asserted
    reset = 1'b1;
    req   = 4'b1111;
    din   = 32'h44332211;
    for (int r = 0; r < 2; r++) begin
      tick(1);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_cap_en", 32'(cap_en), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_q", 32'(q), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
    end

    // Single request, latency; winner drops req in CAPTURE without abort
    reset = 1'b0;
    req   = 4'b0001;
    din   = 32'h000000A5;
    for (int c = 1; c <= 4; c++) begin
      tick(1);
      chk("single_grant", 32'(grant), 32'h1);
      chk("single_busy", 32'(busy), 32'h1);
      chk("single_cap_en", 32'(cap_en), (c == 4) ? 32'h1 : 32'h0);
      chk("single_done_early", 32'(done), 32'h0);
    end
    req = 4'b0000;
    tick(1);
    chk("single_q", 32'(q), 32'hA5);
    chk("single_done", 32'(done), 32'h1);
    chk("single_done_id", 32'(done_id), 32'h0);
    chk("single_grant_off", 32'(grant), 32'h0);
    chk("single_cap_off", 32'(cap_en), 32'h0);
    tick(1);
    chk("single_done_pulse", 32'(done), 32'h0);
    chk("single_idle", 32'(busy), 32'h0);
    chk("single_no_grant", 32'(grant), 32'h0);

    // Round robin with all requests held
    reset = 1'b1;
    tick(1);
    chk("rr_rst_q", 32'(q), 32'h0);
    reset = 1'b0;
    req   = 4'b1111;
    din   = 32'h44332211;
    for (int c = 1; c <= 25; c++) begin
      tick(1);
      chk("rr_onehot", 32'($countones(grant) <= 1), 32'h1);
      if (c % 5 == 0) begin
        chk("rr_done", 32'(done), 32'h1);
        chk("rr_done_id", 32'(done_id), 32'((c / 5 - 1) % 4));
        chk("rr_q", 32'(q), 32'(8'h11 * ((c / 5 - 1) % 4 + 1)));
        chk("rr_grant_gap", 32'(grant), 32'h0);
        chk("rr_busy_gap", 32'(busy), 32'h0);
      end else begin
        chk("rr_no_done", 32'(done), 32'h0);
        chk("rr_grant", 32'(grant), 32'(1 << (((c - 1) / 5) % 4)));
        chk("rr_cap_en", 32'(cap_en), (c % 5 == 4) ? 32'h1 : 32'h0);
      end
    end
    req = 4'b0000;

    // Abort: capture requester 3 first so ptr=0 and q is non-zero
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    req   = 4'b1000;
    tick(4);
    chk("pre_cap_en", 32'(cap_en), 32'h1);
    req = 4'b0000;
    tick(1);
    chk("pre_done", 32'(done), 32'h1);
    chk("pre_done_id", 32'(done_id), 32'h3);
    chk("pre_q", 32'(q), 32'h44);
    req = 4'b0100;
    tick(1);
    chk("abort_grant1", 32'(grant), 32'h4);
    tick(1);
    chk("abort_grant2", 32'(grant), 32'h4);
    req = 4'b0000;
    tick(1);
    chk("abort_grant_off", 32'(grant), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_cap_en", 32'(cap_en), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_q", 32'(q), 32'h44);
    req = 4'b1111;
    tick(1);
    chk("abort_next_grant", 32'(grant), 32'h1);
    chk("abort_next_done", 32'(done), 32'h0);
    chk("abort_next_q", 32'(q), 32'h44);

    // Reset during CAPTURE
    tick(3);
    chk("rstcap_cap_en", 32'(cap_en), 32'h1);
    chk("rstcap_grant", 32'(grant), 32'h1);
    reset = 1'b1;
    tick(1);
    chk("rstcap_q", 32'(q), 32'h0);
    chk("rstcap_done", 32'(done), 32'h0);
    chk("rstcap_grant_off", 32'(grant), 32'h0);
    chk("rstcap_cap_off", 32'(cap_en), 32'h0);
    chk("rstcap_busy", 32'(busy), 32'h0);
    chk("rstcap_done_id", 32'(done_id), 32'h0);
    reset = 1'b0;
    tick(1);
    chk("rstcap_next_grant", 32'(grant), 32'h1);

    // Three completions and one abort since the last reset
    tick(4);
    chk("st_done0", 32'(done), 32'h1);
    chk("st_id0", 32'(done_id), 32'h0);
    chk("st_q0", 32'(q), 32'h11);
    tick(1);
    chk("st_grant1", 32'(grant), 32'h2);
    tick(4);
    chk("st_done1", 32'(done), 32'h1);
    chk("st_id1", 32'(done_id), 32'h1);
    chk("st_q1", 32'(q), 32'h22);
    tick(1);
    chk("st_grant2", 32'(grant), 32'h4);
    req = 4'b1011;
    tick(1);
    chk("st_abort_grant", 32'(grant), 32'h0);
    chk("st_abort_done", 32'(done), 32'h0);
    chk("st_abort_q", 32'(q), 32'h22);
    tick(1);
    chk("st_grant3", 32'(grant), 32'h8);
    tick(3);
    chk("st_cap_en3", 32'(cap_en), 32'h1);
    req = 4'b0000;
    tick(1);
    chk("st_done3", 32'(done), 32'h1);
    chk("st_id3", 32'(done_id), 32'h3);
    chk("st_q3", 32'(q), 32'h44);
`ifdef CAPTURE_ARB_STATS_EN
    chk("st_cap_count", 32'(cap_count), 32'h3);
`endif
    tick(1);
    chk("st_idle", 32'(busy), 32'h0);
    chk("st_done_pulse", 32'(done), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
